// File: rtl/i2c_cfg_seq_pkg.sv
// Shared definitions for the I2C power-up configuration sequencer:
// FSM encoding, command direction codes and table-entry layout.
package i2c_cfg_pkg;

    // FSM state encoding
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_PWRUP   = 4'd1;
    localparam logic [3:0] ST_FETCH   = 4'd2;
    localparam logic [3:0] ST_WR_REQ  = 4'd3;
    localparam logic [3:0] ST_WR_WAIT = 4'd4;
    localparam logic [3:0] ST_RD_REQ  = 4'd5;
    localparam logic [3:0] ST_RD_WAIT = 4'd6;
    localparam logic [3:0] ST_GAP     = 4'd7;
    localparam logic [3:0] ST_NEXT    = 4'd8;
    localparam logic [3:0] ST_RETRY   = 4'd9;
    localparam logic [3:0] ST_DONE    = 4'd10;
    localparam logic [3:0] ST_FAIL    = 4'd11;

    // Command direction on cmd_rw
    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

    // Table entry layout: {reg_addr, value}
    localparam int ENT_REG_MSB = 15;
    localparam int ENT_REG_LSB = 8;
    localparam int ENT_VAL_MSB = 7;
    localparam int ENT_VAL_LSB = 0;

    // Board video-input device
    localparam logic [6:0] DEF_DEV_ADDR = 7'h48;

    typedef struct packed {
        logic [ENT_REG_MSB-ENT_REG_LSB:0] addr;
        logic [ENT_VAL_MSB-ENT_VAL_LSB:0] val;
    } tbl_ent_t;

endpackage

// File: rtl/i2c_cfg_seq_if.sv
// Command/response channel between the configuration sequencer (master)
// and the byte-level I2C engine (slave).
interface i2c_cfg_seq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_nack, rsp_rdata
    );

endinterface

// File: rtl/i2c_cfg_seq_timer.sv
// Loadable saturating down-counter. 'expired' is high once the count has
// reached 1 or 0, so a state that loads N and waits for 'expired' while
// enabled stays exactly N cycles (one cycle for N = 0).
module i2c_cfg_timer #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Load on state entry, otherwise count down while enabled and stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt <= W'(1));

endmodule

// File: rtl/i2c_cfg_seq.sv
// Power-up configuration sequencer: walks an external register LUT and
// issues one I2C write per entry (optionally read back and compared),
// retrying on NACK or mismatch up to MAX_RETRY extra times per entry.
module i2c_cfg_seq
    import i2c_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = DEF_DEV_ADDR,
    parameter int          NUM_REGS  = 3,
    parameter logic [19:0] PWRUP_CYC = 20'd524272,
    parameter logic [15:0] GAP_CYC   = 16'd2700,
    parameter bit          VERIFY    = 1'b1,
    parameter int          MAX_RETRY = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [4:0]    tbl_idx,
    input  logic [15:0]   tbl_data,
    i2c_cfg_seq_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [4:0]    err_idx
);

    localparam logic [4:0] LAST_IDX  = (NUM_REGS > 0) ? 5'(NUM_REGS - 1) : 5'd0;
    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

    logic [3:0] state;
    logic [3:0] state_nx;
    logic [3:0] next_step;
    logic       fetch_ph;
    logic [2:0] retry_cnt;
    logic [4:0] idx_q;
    logic [7:0] reg_q;
    logic [7:0] val_q;
    logic       error_q;
    logic [4:0] err_idx_q;
    logic       xfer;
    logic       pwr_load;
    logic       pwr_exp;
    logic       gap_load;
    logic       gap_exp;
    tbl_ent_t   ent;

    assign ent  = tbl_ent_t'(tbl_data);
    assign xfer = bus.cmd_valid && bus.cmd_ready;

    // Timers are loaded on the edge that enters their state
    assign pwr_load = (state_nx == ST_PWRUP) && (state != ST_PWRUP);
    assign gap_load = (state_nx == ST_GAP) && (state != ST_GAP);

    i2c_cfg_timer #(
        .W       (20),
        .RST_VAL (PWRUP_CYC)
    ) u_pwrup_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pwr_load),
        .load_val (PWRUP_CYC),
        .en       (state == ST_PWRUP),
        .expired  (pwr_exp)
    );

    i2c_cfg_timer #(
        .W       (16),
        .RST_VAL (16'd0)
    ) u_gap_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (GAP_CYC),
        .en       (state == ST_GAP),
        .expired  (gap_exp)
    );

    // Next-state decode; responses are only looked at in the two WAIT states
    always_comb begin
        state_nx = state;
        case (state)
            ST_PWRUP:   if (pwr_exp) state_nx = (NUM_REGS == 0) ? ST_IDLE : ST_FETCH;
            ST_FETCH:   if (fetch_ph) state_nx = ST_WR_REQ;
            ST_WR_REQ:  if (xfer) state_nx = ST_WR_WAIT;
            ST_WR_WAIT: if (bus.rsp_valid) state_nx = bus.rsp_nack ? ST_RETRY : ST_GAP;
            ST_RD_REQ:  if (xfer) state_nx = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (bus.rsp_valid) begin
                    state_nx = (bus.rsp_nack || (bus.rsp_rdata != val_q)) ? ST_RETRY : ST_GAP;
                end
            end
            ST_GAP:     if (gap_exp) state_nx = next_step;
            ST_NEXT:    state_nx = (idx_q == LAST_IDX) ? ST_DONE : ST_FETCH;
            ST_RETRY:   state_nx = (retry_cnt == RETRY_LIM) ? ST_FAIL : ST_GAP;
            ST_IDLE:    state_nx = ST_DONE;
            ST_DONE,
            ST_FAIL:    if (start) state_nx = ST_PWRUP;
            default:    state_nx = ST_PWRUP;
        endcase
    end

    // State register plus per-state bookkeeping (entry latch, index, retries, error)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PWRUP;
            next_step <= ST_NEXT;
            fetch_ph  <= 1'b0;
            retry_cnt <= 3'd0;
            idx_q     <= 5'd0;
            reg_q     <= 8'd0;
            val_q     <= 8'd0;
            error_q   <= 1'b0;
            err_idx_q <= 5'd0;
        end else begin
            state <= state_nx;
            case (state)
                ST_FETCH: begin
                    // First cycle covers LUT latency, second captures the entry
                    fetch_ph <= ~fetch_ph;
                    if (fetch_ph) begin
                        reg_q <= ent.addr;
                        val_q <= ent.val;
                    end
                end
                ST_WR_WAIT: begin
                    if (bus.rsp_valid && !bus.rsp_nack) begin
                        next_step <= VERIFY ? ST_RD_REQ : ST_NEXT;
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.rsp_valid) next_step <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (idx_q != LAST_IDX) begin
                        idx_q     <= idx_q + 5'd1;
                        retry_cnt <= 3'd0;
                    end
                end
                ST_RETRY: begin
                    if (retry_cnt == RETRY_LIM) begin
                        error_q   <= 1'b1;
                        err_idx_q <= idx_q;
                    end else begin
                        retry_cnt <= retry_cnt + 3'd1;
                        next_step <= ST_WR_REQ;
                    end
                end
                ST_DONE, ST_FAIL: begin
                    if (start) begin
                        idx_q     <= 5'd0;
                        retry_cnt <= 3'd0;
                        error_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Command fields are pure decodes of registered state, so the async
    // reset drops cmd_valid immediately and fields hold while stalled.
    assign bus.cmd_valid = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign bus.cmd_rw    = (state == ST_RD_REQ) ? CMD_RD : CMD_WR;
    assign bus.cmd_dev   = DEV_ADDR;
    assign bus.cmd_reg   = reg_q;
    assign bus.cmd_wdata = (state == ST_RD_REQ) ? 8'd0 : val_q;

    assign tbl_idx = idx_q;
    assign busy    = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
    assign done    = (state == ST_DONE);
    assign error   = error_q;
    assign err_idx = err_idx_q;

endmodule
